// File: rtl/i2c_cmd_pkg.sv
// Shared constants and state encoding for the I2C command sequencer.
// Register map, CR/SR bit positions and CR command bytes of the I2C core.
package i2c_cmd_pkg;

   localparam logic [2:0] REG_PRERLO = 3'd0;
   localparam logic [2:0] REG_PRERHI = 3'd1;
   localparam logic [2:0] REG_CTR    = 3'd2;
   localparam logic [2:0] REG_TXR    = 3'd3;
   localparam logic [2:0] REG_RXR    = 3'd3;
   localparam logic [2:0] REG_CR     = 3'd4;
   localparam logic [2:0] REG_SR     = 3'd4;

   localparam int CR_STA   = 7;
   localparam int CR_STO   = 6;
   localparam int CR_RD    = 5;
   localparam int CR_WR    = 4;
   localparam int CR_ACK   = 3;
   localparam int SR_RXACK = 7;
   localparam int SR_TIP   = 1;

   localparam logic [7:0] CTR_CORE_EN  = 8'h80;
   localparam logic [7:0] CR_STA_WR    = 8'h90;
   localparam logic [7:0] CR_WR_ONLY   = 8'h10;
   localparam logic [7:0] CR_WR_STO    = 8'h50;
   localparam logic [7:0] CR_RD_NK_STO = 8'h68;
   localparam logic [7:0] CR_STO_ONLY  = 8'h40;

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_LOAD_TXR,
      S_ISSUE_CR,
      S_POLL_SR,
      S_CHECK,
      S_READ_RXR,
      S_ABORT_STO,
      S_ABORT_POLL,
      S_RESP
   } seq_state_e;

endpackage

// File: rtl/i2c_bus_access.sv
// Single register access engine towards the I2C core.
// Holds the access until acknowledged, then idles at least one cycle.
module i2c_bus_access (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       rnw_i,
   input  logic [2:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic [2:0] m_address_o,
   output logic       m_chipselect_o,
   output logic       m_write_o,
   output logic       m_read_o,
   output logic [7:0] m_writedata_o,
   input  logic [7:0] m_readdata_i,
   input  logic       m_waitrequest_n_i
);

   logic       act_q, act_d;
   logic       done_q, done_d;
   logic       rnw_q, rnw_d;
   logic [2:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;

   // Launch on start (never in the done cycle), finish on acknowledge
   always_comb begin
      act_d   = act_q;
      done_d  = 1'b0;
      rnw_d   = rnw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (act_q) begin
         if (m_waitrequest_n_i) begin
            act_d  = 1'b0;
            done_d = 1'b1;
            if (rnw_q) rdata_d = m_readdata_i;
         end
      end else if (start_i && !done_q) begin
         act_d   = 1'b1;
         rnw_d   = rnw_i;
         addr_d  = addr_i;
         wdata_d = rnw_i ? 8'h00 : wdata_i;
      end
   end

   // Access registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         act_q   <= 1'b0;
         done_q  <= 1'b0;
         rnw_q   <= 1'b0;
         addr_q  <= 3'd0;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
      end else begin
         act_q   <= act_d;
         done_q  <= done_d;
         rnw_q   <= rnw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign done_o         = done_q;
   assign rdata_o        = rdata_q;
   assign m_address_o    = addr_q;
   assign m_chipselect_o = act_q;
   assign m_write_o      = act_q & ~rnw_q;
   assign m_read_o       = act_q & rnw_q;
   assign m_writedata_o  = wdata_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Turns register read/write commands into I2C core access sequences.
// Initialises the core after reset, polls TIP, aborts with STOP on NACK.
module i2c_cmd_sequencer
   import i2c_cmd_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'd99,
   parameter logic [15:0] POLL_MAX = 16'd4095
) (
   input  logic       av_clk,
   input  logic       av_reset_n,
   output logic [2:0] m_address,
   output logic       m_chipselect,
   output logic       m_write,
   output logic       m_read,
   output logic [7:0] m_writedata,
   input  logic [7:0] m_readdata,
   input  logic       m_waitrequest_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_dev_addr,
   input  logic [7:0] cmd_reg_addr,
   input  logic [7:0] cmd_wdata,
   input  logic       cmd_rnw,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       rsp_timeout,
   output logic       busy
);

   seq_state_e  state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  wd_q, wd_d;
   logic        rnw_q, rnw_d;
   logic [15:0] poll_q, poll_d;
   logic        rxack_q, rxack_d;
   logic [7:0]  res_rd_q, res_rd_d;
   logic        res_nk_q, res_nk_d;
   logic        res_to_q, res_to_d;
   logic        rv_q, rv_d;
   logic [7:0]  rrd_q, rrd_d;
   logic        rnk_q, rnk_d;
   logic        rto_q, rto_d;

   logic        acc_start, acc_rnw, acc_done;
   logic [2:0]  acc_addr;
   logic [7:0]  acc_wdata, acc_rdata;
   logic [7:0]  txr_byte, cr_byte;

   i2c_bus_access u_acc (
      .clk_i             (av_clk),
      .rst_ni            (av_reset_n),
      .start_i           (acc_start),
      .rnw_i             (acc_rnw),
      .addr_i            (acc_addr),
      .wdata_i           (acc_wdata),
      .done_o            (acc_done),
      .rdata_o           (acc_rdata),
      .m_address_o       (m_address),
      .m_chipselect_o    (m_chipselect),
      .m_write_o         (m_write),
      .m_read_o          (m_read),
      .m_writedata_o     (m_writedata),
      .m_readdata_i      (m_readdata),
      .m_waitrequest_n_i (m_waitrequest_n)
   );

   // Byte pair for the current step: address, register, data or re-address
   always_comb begin
      txr_byte = {dev_q, 1'b0};
      cr_byte  = CR_STA_WR;
      unique case (step_q)
         2'd0: begin
            txr_byte = {dev_q, 1'b0};
            cr_byte  = CR_STA_WR;
         end
         2'd1: begin
            txr_byte = reg_q;
            cr_byte  = CR_WR_ONLY;
         end
         2'd2: begin
            txr_byte = rnw_q ? {dev_q, 1'b1} : wd_q;
            cr_byte  = rnw_q ? CR_STA_WR : CR_WR_STO;
         end
         default: begin
            txr_byte = {dev_q, 1'b1};
            cr_byte  = CR_RD_NK_STO;
         end
      endcase
   end

   // Sequencer next state, access requests and response capture
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      dev_d     = dev_q;
      reg_d     = reg_q;
      wd_d      = wd_q;
      rnw_d     = rnw_q;
      poll_d    = poll_q;
      rxack_d   = rxack_q;
      res_rd_d  = res_rd_q;
      res_nk_d  = res_nk_q;
      res_to_d  = res_to_q;
      rv_d      = 1'b0;
      rrd_d     = rrd_q;
      rnk_d     = rnk_q;
      rto_d     = rto_q;
      acc_start = 1'b0;
      acc_rnw   = 1'b0;
      acc_addr  = REG_PRERLO;
      acc_wdata = 8'h00;
      unique case (state_q)
         S_INIT: begin
            acc_start = 1'b1;
            unique case (step_q)
               2'd0: begin
                  acc_addr  = REG_PRERLO;
                  acc_wdata = PRESCALE[7:0];
               end
               2'd1: begin
                  acc_addr  = REG_PRERHI;
                  acc_wdata = PRESCALE[15:8];
               end
               default: begin
                  acc_addr  = REG_CTR;
                  acc_wdata = CTR_CORE_EN;
               end
            endcase
            if (acc_done) begin
               if (step_q == 2'd2) begin
                  step_d  = 2'd0;
                  state_d = S_IDLE;
               end else begin
                  step_d = step_q + 2'd1;
               end
            end
         end
         S_IDLE: begin
            if (cmd_valid) begin
               dev_d    = cmd_dev_addr;
               reg_d    = cmd_reg_addr;
               wd_d     = cmd_wdata;
               rnw_d    = cmd_rnw;
               step_d   = 2'd0;
               res_rd_d = 8'h00;
               res_nk_d = 1'b0;
               res_to_d = 1'b0;
               state_d  = S_LOAD_TXR;
            end
         end
         S_LOAD_TXR: begin
            acc_start = 1'b1;
            acc_addr  = REG_TXR;
            acc_wdata = txr_byte;
            if (acc_done) state_d = S_ISSUE_CR;
         end
         S_ISSUE_CR: begin
            acc_start = 1'b1;
            acc_addr  = REG_CR;
            acc_wdata = cr_byte;
            if (acc_done) begin
               poll_d  = 16'd0;
               state_d = S_POLL_SR;
            end
         end
         S_POLL_SR, S_ABORT_POLL: begin
            acc_start = 1'b1;
            acc_rnw   = 1'b1;
            acc_addr  = REG_SR;
            if (acc_done) begin
               if (!acc_rdata[SR_TIP]) begin
                  rxack_d = acc_rdata[SR_RXACK];
                  if (state_q == S_POLL_SR) begin
                     state_d = S_CHECK;
                  end else begin
                     res_nk_d = 1'b1;
                     state_d  = S_RESP;
                  end
               end else if (poll_q == POLL_MAX) begin
                  res_to_d = 1'b1;
                  state_d  = S_RESP;
               end else begin
                  poll_d = poll_q + 16'd1;
               end
            end
         end
         S_CHECK: begin
            if (step_q == 2'd3) begin
               state_d = S_READ_RXR;
            end else if (rxack_q) begin
               state_d = S_ABORT_STO;
            end else if (step_q == 2'd2 && !rnw_q) begin
               state_d = S_RESP;
            end else begin
               step_d  = step_q + 2'd1;
               state_d = (step_q == 2'd2) ? S_ISSUE_CR : S_LOAD_TXR;
            end
         end
         S_READ_RXR: begin
            acc_start = 1'b1;
            acc_rnw   = 1'b1;
            acc_addr  = REG_RXR;
            if (acc_done) begin
               res_rd_d = acc_rdata;
               state_d  = S_RESP;
            end
         end
         S_ABORT_STO: begin
            acc_start = 1'b1;
            acc_addr  = REG_CR;
            acc_wdata = CR_STO_ONLY;
            if (acc_done) begin
               poll_d  = 16'd0;
               state_d = S_ABORT_POLL;
            end
         end
         S_RESP: begin
            rv_d    = 1'b1;
            rrd_d   = res_rd_q;
            rnk_d   = res_nk_q;
            rto_d   = res_to_q;
            state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
   end

   // Sequencer state and response registers
   always_ff @(posedge av_clk or negedge av_reset_n) begin
      if (!av_reset_n) begin
         state_q  <= S_INIT;
         step_q   <= 2'd0;
         dev_q    <= 7'd0;
         reg_q    <= 8'h00;
         wd_q     <= 8'h00;
         rnw_q    <= 1'b0;
         poll_q   <= 16'd0;
         rxack_q  <= 1'b0;
         res_rd_q <= 8'h00;
         res_nk_q <= 1'b0;
         res_to_q <= 1'b0;
         rv_q     <= 1'b0;
         rrd_q    <= 8'h00;
         rnk_q    <= 1'b0;
         rto_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         dev_q    <= dev_d;
         reg_q    <= reg_d;
         wd_q     <= wd_d;
         rnw_q    <= rnw_d;
         poll_q   <= poll_d;
         rxack_q  <= rxack_d;
         res_rd_q <= res_rd_d;
         res_nk_q <= res_nk_d;
         res_to_q <= res_to_d;
         rv_q     <= rv_d;
         rrd_q    <= rrd_d;
         rnk_q    <= rnk_d;
         rto_q    <= rto_d;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign rsp_valid   = rv_q;
   assign rsp_rdata   = rrd_q;
   assign rsp_nack    = rnk_q;
   assign rsp_timeout = rto_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Testbench for i2c_cmd_sequencer with a behavioural I2C core model.
// Command vectors from a table plus reset and busy corner sequences.
module tb_i2c_cmd_sequencer;

   logic       av_clk = 1'b0;
   logic       av_reset_n = 1'b0;
   logic [2:0] m_address;
   logic       m_chipselect, m_write, m_read;
   logic [7:0] m_writedata;
   logic [7:0] m_readdata = 8'hEE;
   logic       m_waitrequest_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_dev_addr = 7'd0;
   logic [7:0] cmd_reg_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       cmd_rnw = 1'b0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack, rsp_timeout, busy;

   always #5 av_clk = ~av_clk;

   i2c_cmd_sequencer #(
      .PRESCALE (16'd99),
      .POLL_MAX (16'd8)
   ) dut (
      .av_clk          (av_clk),
      .av_reset_n      (av_reset_n),
      .m_address       (m_address),
      .m_chipselect    (m_chipselect),
      .m_write         (m_write),
      .m_read          (m_read),
      .m_writedata     (m_writedata),
      .m_readdata      (m_readdata),
      .m_waitrequest_n (m_waitrequest_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_dev_addr    (cmd_dev_addr),
      .cmd_reg_addr    (cmd_reg_addr),
      .cmd_wdata       (cmd_wdata),
      .cmd_rnw         (cmd_rnw),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_nack        (rsp_nack),
      .rsp_timeout     (rsp_timeout),
      .busy            (busy)
   );

   typedef struct {
      logic       rnw;
      logic [2:0] addr;
      logic [7:0] data;
   } acc_t;

   typedef struct {
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] wd;
      logic       rnw;
      int         nack_at;
      int         tip;
      logic [7:0] rx;
      logic [7:0] e_rdata;
      logic       e_nack;
      logic       e_to;
      int         e_ncr;
      int         e_ntxr;
      int         e_nsr;
      logic [7:0] e_last;
      logic [7:0] e_txr0;
   } vec_t;

   acc_t        log_q[$];
   logic [10:0] exq[$];
   int          nv = 0;
   int          nbad = 0;
   int          viol = 0;
   int          cr_cnt = 0;
   int          tip_left = 0;
   int          lat = 0;
   logic        rxack = 1'b0;
   int          tip_n = 0;
   int          nack_cr = -1;
   logic [7:0]  rx_byte = 8'h00;

   // I2C core model: one wait cycle, one-cycle acknowledge, TIP/RxACK script
   always @(negedge av_clk) begin
      if (!av_reset_n) begin
         m_waitrequest_n = 1'b0;
         m_readdata = 8'hEE;
         lat = 0;
      end else if (m_waitrequest_n) begin
         m_waitrequest_n = 1'b0;
         m_readdata = 8'hEE;
         if (m_chipselect) viol++;
      end else if (m_chipselect) begin
         if (m_read == m_write) viol++;
         if (lat < 1) begin
            lat++;
         end else begin
            lat = 0;
            m_waitrequest_n = 1'b1;
            if (m_write) begin
               if (m_address == 3'd4) begin
                  cr_cnt++;
                  tip_left = tip_n;
                  rxack = (cr_cnt == nack_cr);
               end
            end else if (m_address == 3'd4) begin
               m_readdata = {rxack, 5'b0, (tip_left != 0), 1'b0};
               if (tip_left != 0 && tip_n < 255) tip_left--;
            end else begin
               m_readdata = rx_byte;
            end
            log_q.push_back('{m_read, m_address,
                              m_read ? m_readdata : m_writedata});
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nv++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_writes(input string nm, input int b, input int e);
      int n;
      n = 0;
      for (int i = b; i < e; i++) begin
         if (!log_q[i].rnw) begin
            if (n < exq.size())
               chk(nm, {21'd0, log_q[i].addr, log_q[i].data}, {21'd0, exq[n]});
            n++;
         end
      end
      chk({nm, "_count"}, n, exq.size());
   endtask

   task automatic wait_ready(input string nm);
      int k;
      k = 0;
      while (!cmd_ready && k < 500) begin
         @(negedge av_clk);
         k++;
      end
      chk(nm, cmd_ready, 1'b1);
   endtask

   task automatic run_cmd(input vec_t v, input bit spam, output int base,
                          output logic [7:0] rd, output logic nk,
                          output logic to, output int ncr, output int ntxr,
                          output int nsr, output logic [7:0] last,
                          output logic [7:0] txr0, output logic pulse_ok);
      int k;
      @(negedge av_clk);
      wait_ready("cmd_ready_wait");
      tip_n   = v.tip;
      nack_cr = (v.nack_at == 0) ? -1 : cr_cnt + v.nack_at;
      rx_byte = v.rx;
      base    = log_q.size();
      cmd_valid    = 1'b1;
      cmd_dev_addr = v.dev;
      cmd_reg_addr = v.rg;
      cmd_wdata    = v.wd;
      cmd_rnw      = v.rnw;
      @(negedge av_clk);
      if (spam) begin
         cmd_dev_addr = 7'h11;
         cmd_reg_addr = 8'hEE;
         for (int i = 0; i < 10; i++) @(negedge av_clk);
      end
      cmd_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 3000) begin
         @(negedge av_clk);
         k++;
      end
      chk("rsp_valid_seen", rsp_valid, 1'b1);
      rd = rsp_rdata;
      nk = rsp_nack;
      to = rsp_timeout;
      @(negedge av_clk);
      pulse_ok = !rsp_valid;
      ncr  = 0;
      ntxr = 0;
      nsr  = 0;
      last = 8'h00;
      txr0 = 8'h00;
      for (int i = base; i < log_q.size(); i++) begin
         if (!log_q[i].rnw && log_q[i].addr == 3'd4) begin
            ncr++;
            last = log_q[i].data;
         end
         if (!log_q[i].rnw && log_q[i].addr == 3'd3) begin
            if (ntxr == 0) txr0 = log_q[i].data;
            ntxr++;
         end
         if (log_q[i].rnw && log_q[i].addr == 3'd4) nsr++;
      end
   endtask

   vec_t vt[8];
   int   bases[8];

   initial begin
      int         b, e, k, nrd;
      logic [7:0] rd, last, txr0;
      logic       nk, to, pok, found;
      int         ncr, ntxr, nsr;

      vt[0] = '{7'h39, 8'h41, 8'h10, 1'b0, 0, 2, 8'h00,
                8'h00, 1'b0, 1'b0, 3, 3, 9, 8'h50, 8'h72};
      vt[1] = '{7'h39, 8'h00, 8'h00, 1'b1, 0, 1, 8'h75,
                8'h75, 1'b0, 1'b0, 4, 3, 8, 8'h68, 8'h72};
      vt[2] = '{7'h50, 8'h02, 8'hAB, 1'b0, 1, 0, 8'h00,
                8'h00, 1'b1, 1'b0, 2, 1, 2, 8'h40, 8'hA0};
      vt[3] = '{7'h1A, 8'h7F, 8'h00, 1'b1, 3, 0, 8'h99,
                8'h00, 1'b1, 1'b0, 4, 3, 4, 8'h40, 8'h34};
      vt[4] = '{7'h21, 8'h05, 8'hCC, 1'b0, 3, 1, 8'h00,
                8'h00, 1'b1, 1'b0, 4, 3, 8, 8'h40, 8'h42};
      vt[5] = '{7'h39, 8'h41, 8'h10, 1'b0, 0, 255, 8'h00,
                8'h00, 1'b0, 1'b1, 1, 1, 9, 8'h90, 8'h72};
      vt[6] = '{7'h7F, 8'hFF, 8'h00, 1'b1, 0, 0, 8'hC3,
                8'hC3, 1'b0, 1'b0, 4, 3, 4, 8'h68, 8'hFE};
      vt[7] = '{7'h00, 8'h80, 8'h00, 1'b1, 0, 3, 8'h5A,
                8'h5A, 1'b0, 1'b0, 4, 3, 16, 8'h68, 8'h00};

      repeat (3) @(negedge av_clk);
      chk("reset_outputs",
          {m_chipselect, m_write, m_read, m_address, m_writedata,
           cmd_ready, busy, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata},
          {1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

      b = log_q.size();
      av_reset_n = 1'b1;
      wait_ready("init_done");
      e = log_q.size();
      exq = '{{3'd0, 8'h63}, {3'd1, 8'h00}, {3'd2, 8'h80}};
      chk_writes("init_seq", b, e);
      chk("init_total", e - b, 3);

      for (int i = 0; i < 8; i++) begin
         run_cmd(vt[i], 1'b0, bases[i], rd, nk, to, ncr, ntxr, nsr,
                 last, txr0, pok);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].e_rdata);
         chk($sformatf("v%0d_nack", i), nk, vt[i].e_nack);
         chk($sformatf("v%0d_timeout", i), to, vt[i].e_to);
         chk($sformatf("v%0d_cr_writes", i), ncr, vt[i].e_ncr);
         chk($sformatf("v%0d_txr_writes", i), ntxr, vt[i].e_ntxr);
         chk($sformatf("v%0d_sr_polls", i), nsr, vt[i].e_nsr);
         chk($sformatf("v%0d_last_cr", i), last, vt[i].e_last);
         chk($sformatf("v%0d_first_txr", i), txr0, vt[i].e_txr0);
         chk($sformatf("v%0d_pulse", i), pok, 1'b1);
      end

      exq = '{{3'd3, 8'h72}, {3'd4, 8'h90}, {3'd3, 8'h41},
              {3'd4, 8'h10}, {3'd3, 8'h10}, {3'd4, 8'h50}};
      chk_writes("write_seq", bases[0], bases[1]);
      exq = '{{3'd3, 8'h72}, {3'd4, 8'h90}, {3'd3, 8'h00},
              {3'd4, 8'h10}, {3'd3, 8'h73}, {3'd4, 8'h90},
              {3'd4, 8'h68}};
      chk_writes("read_seq", bases[1], bases[2]);
      nrd = 0;
      for (int i = bases[1]; i < bases[2]; i++)
         if (log_q[i].rnw && log_q[i].addr == 3'd3) nrd++;
      chk("read_rxr_once", nrd, 1);

      run_cmd(vt[0], 1'b1, b, rd, nk, to, ncr, ntxr, nsr, last, txr0, pok);
      chk("busy_ignore_cr", ncr, 3);
      chk("busy_ignore_txr0", txr0, 8'h72);
      chk("busy_ignore_nack", {nk, to}, 2'b00);

      @(negedge av_clk);
      wait_ready("pre_reset_ready");
      tip_n = 255;
      nack_cr = -1;
      cmd_valid = 1'b1;
      cmd_dev_addr = 7'h39;
      cmd_reg_addr = 8'h41;
      cmd_wdata = 8'h10;
      cmd_rnw = 1'b0;
      @(negedge av_clk);
      cmd_valid = 1'b0;
      found = 1'b0;
      k = 0;
      while (!found && k < 2000) begin
         @(negedge av_clk);
         found = m_chipselect && m_read && (m_address == 3'd4);
         k++;
      end
      chk("poll_seen", found, 1'b1);
      #1 av_reset_n = 1'b0;
      #1;
      chk("mid_reset_strobes", {m_chipselect, m_write, m_read}, 3'b000);
      chk("mid_reset_status", {cmd_ready, busy}, 2'b01);
      repeat (3) @(negedge av_clk);
      b = log_q.size();
      av_reset_n = 1'b1;
      wait_ready("reinit_done");
      e = log_q.size();
      exq = '{{3'd0, 8'h63}, {3'd1, 8'h00}, {3'd2, 8'h80}};
      chk_writes("reinit_seq", b, e);
      chk("reinit_total", e - b, 3);

      chk("bus_protocol", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nv, nbad);
      $finish;
   end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'd99, I2C core prescale value (100 MHz clock, 200 kHz SCL).
REQ-002 SHALL have parameter POLL_MAX, default 16'd4095, maximum status polls per byte before timeout.
REQ-003 SHALL have port av_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port av_reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port m_address, output, 3, I2C core register address.
REQ-006 SHALL have ports m_chipselect, m_write and m_read, each output, 1, access strobes.
REQ-007 SHALL have ports m_writedata, output, 8, and m_readdata, input, 8.
REQ-008 SHALL have port m_waitrequest_n, input, 1, one-cycle access acknowledge from the I2C core.
REQ-009 SHALL have ports cmd_valid, input, 1, and cmd_ready, output, 1, command handshake.
REQ-010 SHALL have ports cmd_dev_addr, input, 7; cmd_reg_addr, input, 8; cmd_wdata, input, 8; cmd_rnw, input, 1 (1 = read).
REQ-011 SHALL have ports rsp_valid, output, 1 (one-cycle pulse); rsp_rdata, output, 8; rsp_nack, output, 1; rsp_timeout, output, 1.
REQ-012 SHALL have port busy, output, 1, high from reset release until idle, and while a command executes.

Function
REQ-013 Core register map SHALL be: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR (write) / RXR (read), 4 CR (write) / SR (read).
REQ-014 Access rule: m_address, m_writedata and the strobes SHALL be held until m_waitrequest_n=1 is sampled, dropped the next cycle, with at least one idle cycle between accesses.
REQ-015 Init after reset SHALL write PRERlo=PRESCALE[7:0], then PRERhi=PRESCALE[15:8], then CTR=0x80; cmd_ready SHALL stay low until init completes.
REQ-016 cmd_ready SHALL be high only in IDLE; a command is accepted on cmd_valid&cmd_ready and all cmd_* fields are registered.
REQ-017 Each byte SHALL be sent as a TXR write, then a CR write, then SR polling until TIP (bit1)=0.
REQ-018 After a transmit byte, SR bit7 (RxACK)=1 SHALL trigger ABORT.
REQ-019 Write sequence SHALL be: {dev,0}/CR=0x90; reg/CR=0x10; wdata/CR=0x50.
REQ-020 Read sequence SHALL be: {dev,0}/CR=0x90; reg/CR=0x10; {dev,1}/CR=0x90 (repeated start); CR=0x68 (RD, NACK, STO); poll; read RXR into rsp_rdata.
REQ-021 ABORT SHALL write CR=0x40 (STO), poll until TIP=0, then respond with rsp_nack=1.
REQ-022 If polls exceed POLL_MAX, the block SHALL respond with rsp_timeout=1 with no further bus access.
REQ-023 rsp_valid SHALL pulse for one cycle on return to IDLE; rsp_* SHALL hold until the next response.
REQ-024 On a successful write, rsp_rdata SHALL be 0x00.
REQ-025 Poll counter SHALL be 16 bits, cleared at each CR write, and saturate at POLL_MAX.
REQ-026 States SHALL be: INIT, IDLE, LOAD_TXR, ISSUE_CR, POLL_SR, CHECK, READ_RXR, ABORT_STO, ABORT_POLL, RESP.
REQ-027 cmd_valid while busy SHALL be ignored, with no queueing.
REQ-028 m_readdata SHALL be sampled only in the cycle m_waitrequest_n=1 during a read.

Reset
REQ-029 On av_reset_n low, all state SHALL clear asynchronously: strobes 0, m_address 0, m_writedata 0x00, cmd_ready 0, rsp_* 0, busy 1, state INIT.
REQ-030 Reset mid-operation SHALL abandon the access without a STOP; init SHALL re-run after release.

Structure
REQ-031 Package i2c_cmd_pkg SHALL hold register address constants, CR/SR bit positions, CR command bytes (0x90, 0x10, 0x50, 0x68, 0x40) and the state enum.
REQ-032 Sub-module i2c_bus_access SHALL implement the single-access engine (start, rnw, addr, wdata -> done, rdata); the sequencer FSM SHALL instantiate it once.

Verification
REQ-033 Reset release -> writes 0x63@0, 0x00@1, 0x80@2 in order, then cmd_ready=1.
REQ-034 Write dev=0x39, reg=0x41, data=0x10 with slave ACKing -> TXR/CR pairs 0x72/0x90, 0x41/0x10, 0x10/0x50; rsp_valid with nack=0, timeout=0.
REQ-035 Read dev=0x39, reg=0x00 with slave returning 0x75 -> CR sequence 0x90, 0x10, 0x90 (TXR 0x73), 0x68; rsp_rdata=0x75.
REQ-036 RxACK=1 after the address byte -> CR=0x40 written, rsp_nack=1, no reg byte sent.
REQ-037 SR TIP stuck at 1 with POLL_MAX=8 -> rsp_timeout=1 after 9 polls; next command is accepted.
REQ-038 av_reset_n low during POLL_SR -> strobes 0 the same cycle; init sequence repeats after release.
